// File: rtl/memory_stage.sv
// memory_stage: MIPS ME stage with req/ack data-memory access, timeout recovery and the ME/WB register
module memory_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        AnyStall,
  input  logic [31:0] Result_EX,
  input  logic [31:0] WrDat_EX,
  input  logic [4:0]  WriteReg_EX,
  input  logic        RegWrite_EX,
  input  logic        MemToReg_EX,
  input  logic        MemWrite_EX,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWrDat,
  input  logic        DMemAck,
  input  logic [31:0] DMemRdDat,
  output logic [31:0] ResultRdDat_ME,
  output logic [4:0]  WriteReg_ME,
  output logic        RegWrite_ME,
  output logic        Stall_ME,
  output logic        DMemErr
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [7:0] TMAX = 8'(TIMEOUT);
  state_t state;
  logic [31:0] rdHold, loadData;
  logic [7:0] tCnt;
  logic memOp, isLoad, timeOut, complete;
  assign memOp = MemToReg_EX | MemWrite_EX;
  assign isLoad = MemToReg_EX & ~MemWrite_EX;
  assign timeOut = state == WAIT && !DMemAck && tCnt == TMAX;
  assign complete = (state == IDLE && memOp && DMemAck) || (state == WAIT && (DMemAck || tCnt == TMAX));
  assign DMemReq = (state == IDLE && memOp) || state == WAIT;
  assign DMemWe = MemWrite_EX;
  assign DMemAddr = Result_EX;
  assign DMemWrDat = WrDat_EX;
  assign Stall_ME = DMemReq & ~complete;
  // a forced completion returns ERR_DATA; DONE replays the data captured on the ack cycle
  assign loadData = complete ? (timeOut ? ERR_DATA : DMemRdDat) : rdHold;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tCnt <= '0;
      rdHold <= '0;
      DMemErr <= 1'b0;
      ResultRdDat_ME <= '0;
      WriteReg_ME <= '0;
      RegWrite_ME <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      tCnt <= '0;
      ResultRdDat_ME <= '0;
      WriteReg_ME <= '0;
      RegWrite_ME <= 1'b0;
    end else begin
      if (timeOut) DMemErr <= 1'b1;
      if (complete) rdHold <= loadData;
      if (!AnyStall) begin
        ResultRdDat_ME <= isLoad ? loadData : Result_EX;
        WriteReg_ME <= WriteReg_EX;
        RegWrite_ME <= RegWrite_EX;
      end
      tCnt <= state == WAIT ? tCnt + 8'd1 : 8'd1;
      state <= (state == IDLE && memOp && !DMemAck) ? WAIT :
               complete ? (AnyStall ? DONE : IDLE) :
               (state == DONE && !AnyStall) ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of memory_stage with TIMEOUT=4
module tb_memory_stage;
  logic clk = 0, reset, flush, extStall, AnyStall;
  logic [31:0] Result_EX, WrDat_EX, DMemAddr, DMemWrDat, DMemRdDat, ResultRdDat_ME;
  logic [4:0] WriteReg_EX, WriteReg_ME;
  logic RegWrite_EX, MemToReg_EX, MemWrite_EX, DMemReq, DMemWe, DMemAck, RegWrite_ME, Stall_ME, DMemErr;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign AnyStall = Stall_ME | extStall;
  memory_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .AnyStall(AnyStall),
    .Result_EX(Result_EX), .WrDat_EX(WrDat_EX), .WriteReg_EX(WriteReg_EX),
    .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX), .MemWrite_EX(MemWrite_EX),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWrDat(DMemWrDat),
    .DMemAck(DMemAck), .DMemRdDat(DMemRdDat), .ResultRdDat_ME(ResultRdDat_ME),
    .WriteReg_ME(WriteReg_ME), .RegWrite_ME(RegWrite_ME), .Stall_ME(Stall_ME), .DMemErr(DMemErr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    {MemToReg_EX, MemWrite_EX, RegWrite_EX, DMemAck, extStall, flush} = '0;
    Result_EX = '0; WrDat_EX = '0; WriteReg_EX = '0; DMemRdDat = '0;
  endtask
  initial begin
    idle_in();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_res", ResultRdDat_ME, 0);
    chk("rst_wreg", 32'(WriteReg_ME), 0);
    chk("rst_rw", 32'(RegWrite_ME), 0);
    chk("rst_err", 32'(DMemErr), 0);
    chk("rst_req", 32'(DMemReq), 0);
    chk("rst_stall", 32'(Stall_ME), 0);
    // zero-wait load
    MemToReg_EX = 1; RegWrite_EX = 1; WriteReg_EX = 5; Result_EX = 32'h40;
    DMemAck = 1; DMemRdDat = 32'h1234_5678;
    #1;
    chk("ld0_stall", 32'(Stall_ME), 0);
    chk("ld0_req", 32'(DMemReq), 1);
    chk("ld0_we", 32'(DMemWe), 0);
    tick();
    chk("ld0_res", ResultRdDat_ME, 32'h1234_5678);
    chk("ld0_wreg", 32'(WriteReg_ME), 5);
    chk("ld0_rw", 32'(RegWrite_ME), 1);
    idle_in();
    // ALU op
    Result_EX = 32'h7; RegWrite_EX = 1; WriteReg_EX = 3;
    #1;
    chk("alu_req", 32'(DMemReq), 0);
    tick();
    chk("alu_res", ResultRdDat_ME, 32'h7);
    chk("alu_wreg", 32'(WriteReg_ME), 3);
    idle_in();
    // store acked after 3 stall cycles
    MemWrite_EX = 1; Result_EX = 32'h100; WrDat_EX = 32'hCAFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", 32'(Stall_ME), 1);
      chk("st_req", 32'(DMemReq), 1);
      chk("st_we", 32'(DMemWe), 1);
      chk("st_hold", ResultRdDat_ME, 32'h7);
      tick();
    end
    DMemAck = 1;
    #1;
    chk("st_ack_stall", 32'(Stall_ME), 0);
    chk("st_ack_req", 32'(DMemReq), 1);
    chk("st_addr", DMemAddr, 32'h100);
    chk("st_dat", DMemWrDat, 32'hCAFE);
    tick();
    chk("st_res", ResultRdDat_ME, 32'h100);
    chk("st_rw", 32'(RegWrite_ME), 0);
    idle_in();
    // load acked while another stage stalls
    MemToReg_EX = 1; RegWrite_EX = 1; WriteReg_EX = 9; Result_EX = 32'h200;
    DMemAck = 1; DMemRdDat = 32'hA5A5_0001; extStall = 1;
    #1;
    chk("dn_stall", 32'(Stall_ME), 0);
    chk("dn_req", 32'(DMemReq), 1);
    tick();
    DMemAck = 0; DMemRdDat = 32'h0BAD;
    #1;
    chk("dn_req1", 32'(DMemReq), 0);
    chk("dn_hold", ResultRdDat_ME, 32'h100);
    tick();
    chk("dn_req2", 32'(DMemReq), 0);
    extStall = 0;
    #1;
    chk("dn_req3", 32'(DMemReq), 0);
    chk("dn_stall3", 32'(Stall_ME), 0);
    tick();
    chk("dn_res", ResultRdDat_ME, 32'hA5A5_0001);
    chk("dn_wreg", 32'(WriteReg_ME), 9);
    idle_in();
    // timeout
    MemToReg_EX = 1; RegWrite_EX = 1; WriteReg_EX = 7; Result_EX = 32'h300;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", 32'(Stall_ME), 1);
      tick();
    end
    chk("to_stall_last", 32'(Stall_ME), 0);
    chk("to_req_last", 32'(DMemReq), 1);
    chk("to_err_pre", 32'(DMemErr), 0);
    tick();
    chk("to_err", 32'(DMemErr), 1);
    chk("to_res", ResultRdDat_ME, 32'hDEADBEEF);
    chk("to_wreg", 32'(WriteReg_ME), 7);
    idle_in();
    flush = 1;
    tick();
    flush = 0;
    chk("fl_err", 32'(DMemErr), 1);
    chk("fl_res", ResultRdDat_ME, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("rs_err", 32'(DMemErr), 0);
    // flush during WAIT
    Result_EX = 32'h55; RegWrite_EX = 1; WriteReg_EX = 2;
    tick();
    chk("pf_rw", 32'(RegWrite_ME), 1);
    MemToReg_EX = 1; WriteReg_EX = 4; Result_EX = 32'h400;
    tick(); tick();
    chk("pf_stall", 32'(Stall_ME), 1);
    flush = 1;
    tick();
    idle_in();
    #1;
    chk("pf_req", 32'(DMemReq), 0);
    chk("pf_rw0", 32'(RegWrite_ME), 0);
    chk("pf_stall0", 32'(Stall_ME), 0);
    DMemAck = 1; DMemRdDat = 32'hFFFF_FFFF;
    tick();
    chk("late_res", ResultRdDat_ME, 0);
    chk("late_rw", 32'(RegWrite_ME), 0);
    MemToReg_EX = 1; RegWrite_EX = 1; WriteReg_EX = 6; DMemRdDat = 32'h11;
    #1;
    chk("post_stall", 32'(Stall_ME), 0);
    tick();
    chk("post_res", ResultRdDat_ME, 32'h11);
    chk("post_err", 32'(DMemErr), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
